// File: rtl/lights_pkg.sv
// Shared definitions for the lights sequencer: mode encodings, colour index
// range and helpers for stepping the index and deriving per-channel indices.
// No ports (package).
package lights_pkg;

  localparam logic [1:0] MODE_WHITE  = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_MIN = 3'd1;
  localparam logic [IDX_W-1:0] IDX_MAX = 3'd6;

  // Index sequence 1..6, wrapping back to 1.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_MAX) ? IDX_MIN : idx + 3'd1;
  endfunction

  // Channel c shows the colour c steps ahead of the base index, kept in 1..6.
  function automatic logic [IDX_W-1:0] ch_idx(input logic [IDX_W-1:0] idx,
                                               input int unsigned c);
    int unsigned v;
    v = ((32'(idx) - 32'd1 + c) % 32'd6) + 32'd1;
    return v[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/lights_palette.sv
// Combinational palette: maps a 3-bit colour index to one RGB channel.
// Bit 2 drives red, bit 1 green, bit 0 blue; each set bit gives a full-scale
// component, each clear bit gives zero.
// Ports:
//   idx_i  colour index
//   rgb_o  {R,G,B}, COLOUR_W bits each
module lights_palette #(
  parameter int unsigned COLOUR_W = 8
) (
  input  logic [2:0]            idx_i,
  output logic [3*COLOUR_W-1:0] rgb_o
);

  always_comb begin
    rgb_o = {{COLOUR_W{idx_i[2]}}, {COLOUR_W{idx_i[1]}}, {COLOUR_W{idx_i[0]}}};
  end

endmodule

// File: rtl/lights_sequencer.sv
// Multi-channel RGB lights sequencer. A colour index (1..6) is stepped either
// by a rising edge of the button (MANUAL) or by a free-running tick counter
// (AUTO), frozen in HOLD, and ignored in WHITE. Each channel shows the index
// offset by its channel number. Output is white when sel=0 or in WHITE mode.
// The output is fully registered.
// Optional feature: define LIGHTS_DIM_EN to add the dim port, which
// right-shifts each palette component (white is never dimmed).
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-high reset
//   sel     0: all channels white, 1: sequencer output
//   mode    00 WHITE, 01 MANUAL, 10 AUTO, 11 HOLD
//   button  step request, rising edge used
//   dim     per-component right shift (LIGHTS_DIM_EN only)
//   light   NUM_CH channels of {R,G,B}, channel 0 in the low bits
module lights_sequencer
  import lights_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned COLOUR_W    = 8,
  parameter int unsigned AUTO_PERIOD = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sel,
  input  logic [1:0]                   mode,
  input  logic                         button,
`ifdef LIGHTS_DIM_EN
  input  logic [1:0]                   dim,
`endif
  output logic [NUM_CH*3*COLOUR_W-1:0] light
);

  localparam int unsigned ChW    = 3 * COLOUR_W;
  localparam int unsigned LightW = NUM_CH * ChW;
  localparam int unsigned TickW  = $clog2(AUTO_PERIOD);
  localparam logic [TickW-1:0] TickLast = TickW'(AUTO_PERIOD - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              button_q;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [LightW-1:0] light_q, light_d;

  logic btn_edge;
  logic step;

  // Step logic: the mode seen this cycle decides whether an edge or tick counts.
  always_comb begin
    btn_edge = button & ~button_q;
    step     = 1'b0;
    tick_d   = '0;
    idx_d    = idx_q;
    case (mode)
      MODE_MANUAL: step = btn_edge;
      MODE_AUTO: begin
        if (tick_q == TickLast) begin
          step = 1'b1;
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      default: ;
    endcase
    if (step) begin
      idx_d = next_idx(idx_q);
    end
  end

  logic [IDX_W-1:0] ch_sel [NUM_CH];
  logic [ChW-1:0]   ch_rgb [NUM_CH];
  logic [ChW-1:0]   ch_col [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned ChNum = c;

    assign ch_sel[c] = ch_idx(idx_q, ChNum);

    lights_palette #(
      .COLOUR_W (COLOUR_W)
    ) u_palette (
      .idx_i (ch_sel[c]),
      .rgb_o (ch_rgb[c])
    );

`ifdef LIGHTS_DIM_EN
    for (genvar k = 0; k < 3; k++) begin : g_dim
      assign ch_col[c][k*COLOUR_W +: COLOUR_W] = ch_rgb[c][k*COLOUR_W +: COLOUR_W] >> dim;
    end
`else
    assign ch_col[c] = ch_rgb[c];
`endif
  end

  always_comb begin
    light_d = '1;
    if (sel && (mode != MODE_WHITE)) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        light_d[c*ChW +: ChW] = ch_col[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= IDX_MIN;
      button_q <= 1'b0;
      tick_q   <= '0;
      light_q  <= '1;
    end else begin
      idx_q    <= idx_d;
      button_q <= button;
      tick_q   <= tick_d;
      light_q  <= light_d;
    end
  end

  assign light = light_q;

endmodule

// File: tb/tb_lights_sequencer.sv
module tb_lights_sequencer;

  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned COLOUR_W    = 8;
  localparam int unsigned AUTO_PERIOD = 4;
  localparam int unsigned LW          = NUM_CH * 3 * COLOUR_W;

  localparam logic [LW-1:0] WHITE = {LW{1'b1}};

  logic          clk;
  logic          rst;
  logic          sel;
  logic [1:0]    mode;
  logic          button;
  logic [1:0]    dim;
  logic [LW-1:0] light;

  int checks;
  int failures;

  lights_sequencer #(
    .NUM_CH      (NUM_CH),
    .COLOUR_W    (COLOUR_W),
    .AUTO_PERIOD (AUTO_PERIOD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .mode   (mode),
    .button (button),
`ifdef LIGHTS_DIM_EN
    .dim    (dim),
`endif
    .light  (light)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Full-scale light for a given base index, hand-derived: {ch2, ch1, ch0}.
  function automatic logic [LW-1:0] exp_light(input int i);
    case (i)
      1:       return 72'h00FFFF_00FF00_0000FF;
      2:       return 72'hFF0000_00FFFF_00FF00;
      3:       return 72'hFF00FF_FF0000_00FFFF;
      4:       return 72'hFFFF00_FF00FF_FF0000;
      5:       return 72'h0000FF_FFFF00_FF00FF;
      6:       return 72'h00FF00_0000FF_FFFF00;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] expected);
    checks++;
    assert (light === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, light, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    button = 1'b1;
    step_clk();
    button = 1'b0;
    step_clk();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    sel      = 1'b0;
    mode     = 2'b01;
    button   = 1'b0;
    dim      = 2'd0;

    // 1: reset and white output with sel=0
    #2;
    check("reset_async", WHITE);
    step_clk();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_clk();
      check("sel0_white", WHITE);
    end

    // 2: MANUAL at idx=1, then a held button gives one step
    sel = 1'b1;
    step_clk();
    check("manual_idx1", exp_light(1));
    button = 1'b1;
    step_clk();
    check("btn_latency", exp_light(1));
    for (int i = 0; i < 9; i++) begin
      step_clk();
      check("btn_held_one_step", exp_light(2));
    end
    button = 1'b0;
    step_clk();
    check("btn_release", exp_light(2));

    // 3: wrap 2->3->4->5->6->1, then one more to 2
    for (int i = 3; i <= 7; i++) begin
      pulse();
      check("manual_pulse", exp_light(i > 6 ? i - 6 : i));
    end
    pulse();
    check("manual_after_wrap", exp_light(2));

    // WHITE mode and sel=0 keep idx; reselecting resumes the same colour
    mode = 2'b00;
    step_clk();
    check("white_mode", WHITE);
    mode = 2'b01;
    step_clk();
    check("white_resume", exp_light(2));
    sel = 1'b0;
    step_clk();
    check("sel0_again", WHITE);
    sel = 1'b1;
    step_clk();
    check("sel1_resume", exp_light(2));

    // 4: AUTO steps every 4 clocks, button toggling ignored
    mode = 2'b10;
    for (int n = 1; n <= 12; n++) begin
      button = ~button;
      step_clk();
      check("auto_step", exp_light(2 + (n >= 5 ? 1 : 0) + (n >= 9 ? 1 : 0)));
    end
    // a step also landed on the 12th edge, so idx is 5 entering HOLD
    mode = 2'b11;
    for (int n = 0; n < 20; n++) begin
      button = ~button;
      step_clk();
      check("hold_frozen", exp_light(5));
    end
    button = 1'b0;

    // 5: reset in AUTO with tick_cnt=2
    mode = 2'b10;
    step_clk();
    check("auto_tick1", exp_light(5));
    step_clk();
    check("auto_tick2", exp_light(5));
    rst = 1'b1;
    #1;
    check("reset_mid_auto", WHITE);
    step_clk();
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step_clk();
      check("auto_after_reset", exp_light(1));
    end
    step_clk();
    check("auto_first_step", exp_light(2));

`ifdef LIGHTS_DIM_EN
    // 6: dim by 2 at idx=1; white not dimmed
    mode = 2'b01;
    rst  = 1'b1;
    step_clk();
    rst  = 1'b0;
    dim  = 2'd2;
    step_clk();
    check("dim_idx1", 72'h003F3F_003F00_00003F);
    sel = 1'b0;
    step_clk();
    check("dim_white_full", WHITE);
    sel = 1'b1;
    dim = 2'd0;
`endif

    sel = 1'b0;
    step_clk();
    check("final_sel0", WHITE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
